// File: rtl/synaptic_update_ctrl_pkg.sv
// Shared definitions for the synaptic SRAM update controller.
//   - SYN_ADDR_W / NEUR_ADDR_W : SRAM word address and neuron index widths
//   - ctrl_state_t             : controller FSM state encoding
//   - wpp_of()                 : SRAM words per pre neuron for M post neurons
package syn_ctrl_pkg;

  localparam int unsigned SYN_ADDR_W  = 16;
  localparam int unsigned NEUR_ADDR_W = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SW_RD,
    S_SW_WR,
    S_SP_RD,
    S_SP_WR,
    S_SP_ACK
  } ctrl_state_t;

  // Four 8-bit synapses are packed into each 32-bit SRAM word.
  function automatic int unsigned wpp_of(input int unsigned m);
    return (m + 3) / 4;
  endfunction

endpackage

// File: rtl/synaptic_update_ctrl_if.sv
// SPI-side access channel into the synaptic SRAM controller.
//   SPI_REQ   level request, held by the master until SPI_ACK
//   SPI_WE    1 = byte write, 0 = word read
//   SPI_ADDR  SRAM word address
//   SPI_BYTE  byte lane for writes
//   SPI_WDATA write byte
//   SPI_ACK   one-cycle completion pulse
//   SPI_RDATA last word read (registered)
// master = SPI slave block issuing requests, slave = synaptic_update_ctrl.
interface synaptic_update_ctrl_if;
  import syn_ctrl_pkg::*;

  logic                  SPI_REQ;
  logic                  SPI_WE;
  logic [SYN_ADDR_W-1:0] SPI_ADDR;
  logic [1:0]            SPI_BYTE;
  logic [7:0]            SPI_WDATA;
  logic                  SPI_ACK;
  logic [31:0]           SPI_RDATA;

  modport master (
    output SPI_REQ, SPI_WE, SPI_ADDR, SPI_BYTE, SPI_WDATA,
    input  SPI_ACK, SPI_RDATA
  );

  modport slave (
    input  SPI_REQ, SPI_WE, SPI_ADDR, SPI_BYTE, SPI_WDATA,
    output SPI_ACK, SPI_RDATA
  );

endinterface

// File: rtl/synaptic_update_ctrl_sweep_cnt.sv
// Sweep position counter: pre neuron index and post word within that neuron.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return both counters to 0
//   adv        : step to the next word (post_wd wraps at WPP-1, carrying into pre_idx)
//   pre_nxt    : pre_idx value after this edge
//   post_nxt   : post_wd value after this edge
//   addr_nxt   : pre_nxt*WPP + post_nxt, the SRAM word for that position
//   is_last    : current position is (N-1, WPP-1)
// The *_nxt outputs let the owner register SRAM controls in step with the counters.
module syn_sweep_cnt
  import syn_ctrl_pkg::*;
#(
  parameter int unsigned N   = 784,
  parameter int unsigned WPP = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   adv,
  output logic [NEUR_ADDR_W-1:0] pre_nxt,
  output logic [NEUR_ADDR_W-1:0] post_nxt,
  output logic [SYN_ADDR_W-1:0]  addr_nxt,
  output logic                   is_last
);

  logic [NEUR_ADDR_W-1:0] pre_idx;
  logic [NEUR_ADDR_W-1:0] post_wd;

  always_comb begin
    pre_nxt  = pre_idx;
    post_nxt = post_wd;
    if (clr) begin
      pre_nxt  = '0;
      post_nxt = '0;
    end else if (adv) begin
      if (post_wd == NEUR_ADDR_W'(WPP - 1)) begin
        post_nxt = '0;
        pre_nxt  = pre_idx + NEUR_ADDR_W'(1);
      end else begin
        post_nxt = post_wd + NEUR_ADDR_W'(1);
      end
    end
  end

  assign addr_nxt = SYN_ADDR_W'(32'(pre_nxt) * WPP + 32'(post_nxt));
  assign is_last  = (pre_idx == NEUR_ADDR_W'(N - 1)) && (post_wd == NEUR_ADDR_W'(WPP - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_idx <= '0;
      post_wd <= '0;
    end else begin
      pre_idx <= pre_nxt;
      post_wd <= post_nxt;
    end
  end

endmodule

// File: rtl/synaptic_update_ctrl.sv
// Sequencer/arbiter for the synaptic SRAM port of synaptic_core.
//   CLK, RSTN                : clock, asynchronous active-low reset
//   SPI_GATE_ACTIVITY_sync   : 1 = SPI owns the SRAM, 0 = network owns it
//   UPDATE_START             : pulse requesting a full weight-update sweep
//   UPDATE_BUSY/DONE/ABORT   : sweep status (DONE/ABORT are one-cycle pulses)
//   spi                      : SPI access channel (slave side)
//   SYNARRAY_RDATA           : SRAM read data, valid the cycle after a read
//   CTRL_SYNARRAY_CS/WE/ADDR : registered SRAM controls
//   CTRL_POST_NEURON_ADDRESS : post index (sweep) or byte lane in [1:0] (SPI write)
//   CTRL_PRE_NEUR_ADDR       : pre index during the sweep
//   CTRL_SYNA_RD/WR_EVENT    : SPI read / write phase strobes
//   CTRL_SYNA_PROG_DATA      : SPI write byte, captured at acceptance
//   CTRL_TREF_EVENT          : sweep write strobe enabling the STDP update
// A sweep does read/write per word; DONE coincides with the final write cycle.
module synaptic_update_ctrl
  import syn_ctrl_pkg::*;
#(
  parameter int unsigned N = 784,
  parameter int unsigned M = 8
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    SPI_GATE_ACTIVITY_sync,
  input  logic                    UPDATE_START,
  output logic                    UPDATE_BUSY,
  output logic                    UPDATE_DONE,
  output logic                    UPDATE_ABORT,
  synaptic_update_ctrl_if.slave   spi,
  input  logic [31:0]             SYNARRAY_RDATA,
  output logic                    CTRL_SYNARRAY_CS,
  output logic                    CTRL_SYNARRAY_WE,
  output logic [SYN_ADDR_W-1:0]   CTRL_SYNARRAY_ADDR,
  output logic [NEUR_ADDR_W-1:0]  CTRL_POST_NEURON_ADDRESS,
  output logic [NEUR_ADDR_W-1:0]  CTRL_PRE_NEUR_ADDR,
  output logic                    CTRL_SYNA_RD_EVENT,
  output logic                    CTRL_SYNA_WR_EVENT,
  output logic [7:0]              CTRL_SYNA_PROG_DATA,
  output logic                    CTRL_TREF_EVENT
);

  localparam int unsigned WPP = wpp_of(M);

  ctrl_state_t state, state_nxt;

  logic                   gate;
  logic                   cnt_clr, cnt_adv, is_last;
  logic [NEUR_ADDR_W-1:0] cnt_pre_nxt, cnt_post_nxt;
  logic [SYN_ADDR_W-1:0]  cnt_addr_nxt;

  logic                   spi_accept, spi_we_q;
  logic [1:0]             spi_byte_q;
  logic [SYN_ADDR_W-1:0]  spi_addr_q;
  logic                   ack_q, rdata_ld;
  logic [31:0]            rdata_q;

  logic                   busy_d, done_d, abort_d, ack_d;
  logic                   cs_d, we_d, rd_ev_d, wr_ev_d, tref_d;
  logic [SYN_ADDR_W-1:0]  addr_d;
  logic [NEUR_ADDR_W-1:0] post_d, pre_d;

  assign gate          = SPI_GATE_ACTIVITY_sync;
  assign spi.SPI_ACK   = ack_q;
  assign spi.SPI_RDATA = rdata_q;

  syn_sweep_cnt #(
    .N   (N),
    .WPP (WPP)
  ) u_sweep_cnt (
    .clk      (CLK),
    .rst_n    (RSTN),
    .clr      (cnt_clr),
    .adv      (cnt_adv),
    .pre_nxt  (cnt_pre_nxt),
    .post_nxt (cnt_post_nxt),
    .addr_nxt (cnt_addr_nxt),
    .is_last  (is_last)
  );

  always_comb begin
    state_nxt  = state;
    cnt_clr    = 1'b0;
    cnt_adv    = 1'b0;
    spi_accept = 1'b0;
    abort_d    = 1'b0;
    ack_d      = 1'b0;
    rdata_ld   = 1'b0;

    case (state)
      S_IDLE: begin
        // ack_q blocks re-acceptance while the master still holds REQ in the ACK cycle.
        if (UPDATE_START && !gate) begin
          state_nxt = S_SW_RD;
        end else if (spi.SPI_REQ && gate && !ack_q) begin
          state_nxt  = S_SP_RD;
          spi_accept = 1'b1;
        end
      end
      S_SW_RD: state_nxt = S_SW_WR;
      S_SW_WR: begin
        if (is_last) begin
          state_nxt = S_IDLE;
          cnt_clr   = 1'b1;
        end else if (gate) begin
          state_nxt = S_IDLE;
          cnt_clr   = 1'b1;
          abort_d   = 1'b1;
        end else begin
          state_nxt = S_SW_RD;
          cnt_adv   = 1'b1;
        end
      end
      S_SP_RD: state_nxt = spi_we_q ? S_SP_WR : S_SP_ACK;
      S_SP_WR: state_nxt = S_SP_ACK;
      S_SP_ACK: begin
        state_nxt = S_IDLE;
        ack_d     = 1'b1;
        rdata_ld  = !spi_we_q;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // SRAM controls are decoded from the next state so they are registered
  // alongside it; the counter's *_nxt values track the same edge.
  always_comb begin
    busy_d  = 1'b0;
    done_d  = 1'b0;
    cs_d    = 1'b0;
    we_d    = 1'b0;
    rd_ev_d = 1'b0;
    wr_ev_d = 1'b0;
    tref_d  = 1'b0;
    addr_d  = '0;
    post_d  = '0;
    pre_d   = '0;

    case (state_nxt)
      S_SW_RD: begin
        busy_d = 1'b1;
        cs_d   = 1'b1;
        addr_d = cnt_addr_nxt;
        post_d = cnt_post_nxt << 2;
        pre_d  = cnt_pre_nxt;
      end
      S_SW_WR: begin
        busy_d = 1'b1;
        done_d = is_last;
        cs_d   = 1'b1;
        we_d   = 1'b1;
        tref_d = 1'b1;
        addr_d = cnt_addr_nxt;
        post_d = cnt_post_nxt << 2;
        pre_d  = cnt_pre_nxt;
      end
      S_SP_RD: begin
        cs_d    = 1'b1;
        rd_ev_d = 1'b1;
        addr_d  = spi.SPI_ADDR;
      end
      S_SP_WR: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        wr_ev_d = 1'b1;
        addr_d  = spi_addr_q;
        post_d  = NEUR_ADDR_W'(spi_byte_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state                    <= S_IDLE;
      spi_we_q                 <= 1'b0;
      spi_byte_q               <= '0;
      spi_addr_q               <= '0;
      ack_q                    <= 1'b0;
      rdata_q                  <= '0;
      UPDATE_BUSY              <= 1'b0;
      UPDATE_DONE              <= 1'b0;
      UPDATE_ABORT             <= 1'b0;
      CTRL_SYNARRAY_CS         <= 1'b0;
      CTRL_SYNARRAY_WE         <= 1'b0;
      CTRL_SYNARRAY_ADDR       <= '0;
      CTRL_POST_NEURON_ADDRESS <= '0;
      CTRL_PRE_NEUR_ADDR       <= '0;
      CTRL_SYNA_RD_EVENT       <= 1'b0;
      CTRL_SYNA_WR_EVENT       <= 1'b0;
      CTRL_SYNA_PROG_DATA      <= '0;
      CTRL_TREF_EVENT          <= 1'b0;
    end else begin
      state                    <= state_nxt;
      ack_q                    <= ack_d;
      UPDATE_BUSY              <= busy_d;
      UPDATE_DONE              <= done_d;
      UPDATE_ABORT             <= abort_d;
      CTRL_SYNARRAY_CS         <= cs_d;
      CTRL_SYNARRAY_WE         <= we_d;
      CTRL_SYNARRAY_ADDR       <= addr_d;
      CTRL_POST_NEURON_ADDRESS <= post_d;
      CTRL_PRE_NEUR_ADDR       <= pre_d;
      CTRL_SYNA_RD_EVENT       <= rd_ev_d;
      CTRL_SYNA_WR_EVENT       <= wr_ev_d;
      CTRL_TREF_EVENT          <= tref_d;
      if (spi_accept) begin
        spi_we_q            <= spi.SPI_WE;
        spi_byte_q          <= spi.SPI_BYTE;
        spi_addr_q          <= spi.SPI_ADDR;
        CTRL_SYNA_PROG_DATA <= spi.SPI_WDATA;
      end
      if (rdata_ld) rdata_q <= SYNARRAY_RDATA;
    end
  end

endmodule

// File: tb/tb_synaptic_update_ctrl.sv
module tb_synaptic_update_ctrl;

  localparam int N1 = 784;
  localparam int W1 = 2;
  localparam int SW1 = 2 * N1 * W1;  // 3136
  localparam int N2 = 3;
  localparam int W2 = 2;
  localparam int SW2 = 2 * N2 * W2;  // 12

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic        rst_n, gate, start;
  logic [31:0] sram_rdata;
  logic        busy, done, abort, cs, we, rd_ev, wr_ev, tref;
  logic [15:0] addr;
  logic [9:0]  post, pre;
  logic [7:0]  prog;
  synaptic_update_ctrl_if spi ();

  logic        gate2, start2;
  logic [31:0] sram_rdata2;
  logic        busy2, done2, abort2, cs2, we2, rd_ev2, wr_ev2, tref2;
  logic [15:0] addr2;
  logic [9:0]  post2, pre2;
  logic [7:0]  prog2;
  synaptic_update_ctrl_if spi2 ();

  synaptic_update_ctrl #(.N(N1), .M(8)) dut (
    .CLK(clk), .RSTN(rst_n), .SPI_GATE_ACTIVITY_sync(gate), .UPDATE_START(start),
    .UPDATE_BUSY(busy), .UPDATE_DONE(done), .UPDATE_ABORT(abort), .spi(spi.slave),
    .SYNARRAY_RDATA(sram_rdata), .CTRL_SYNARRAY_CS(cs), .CTRL_SYNARRAY_WE(we),
    .CTRL_SYNARRAY_ADDR(addr), .CTRL_POST_NEURON_ADDRESS(post), .CTRL_PRE_NEUR_ADDR(pre),
    .CTRL_SYNA_RD_EVENT(rd_ev), .CTRL_SYNA_WR_EVENT(wr_ev), .CTRL_SYNA_PROG_DATA(prog),
    .CTRL_TREF_EVENT(tref)
  );

  synaptic_update_ctrl #(.N(N2), .M(5)) dut2 (
    .CLK(clk), .RSTN(rst_n), .SPI_GATE_ACTIVITY_sync(gate2), .UPDATE_START(start2),
    .UPDATE_BUSY(busy2), .UPDATE_DONE(done2), .UPDATE_ABORT(abort2), .spi(spi2.slave),
    .SYNARRAY_RDATA(sram_rdata2), .CTRL_SYNARRAY_CS(cs2), .CTRL_SYNARRAY_WE(we2),
    .CTRL_SYNARRAY_ADDR(addr2), .CTRL_POST_NEURON_ADDRESS(post2), .CTRL_PRE_NEUR_ADDR(pre2),
    .CTRL_SYNA_RD_EVENT(rd_ev2), .CTRL_SYNA_WR_EVENT(wr_ev2), .CTRL_SYNA_PROG_DATA(prog2),
    .CTRL_TREF_EVENT(tref2)
  );

  logic [84:0] all_out, all_out2;
  logic [43:0] mon1, mon2;
  assign all_out  = {busy, done, abort, spi.SPI_ACK, spi.SPI_RDATA, cs, we, addr, post, pre,
                     rd_ev, wr_ev, prog, tref};
  assign all_out2 = {busy2, done2, abort2, spi2.SPI_ACK, spi2.SPI_RDATA, cs2, we2, addr2, post2,
                     pre2, rd_ev2, wr_ev2, prog2, tref2};
  assign mon1 = {cs, we, tref, busy, done, abort, rd_ev, wr_ev, addr, post, pre};
  assign mon2 = {cs2, we2, tref2, busy2, done2, abort2, rd_ev2, wr_ev2, addr2, post2, pre2};

  // SRAM + synaptic_core byte-merge model for dut
  logic [31:0] mem [0:65535];
  logic        ld;
  logic [15:0] ld_addr;
  logic [31:0] ld_data;

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] lane,
                                        input logic [7:0] b);
    logic [31:0] r;
    int unsigned sh;
    r  = w;
    sh = 32'(lane);
    r[sh*8 +: 8] = b;
    return r;
  endfunction

  always @(posedge clk) begin
    if (ld) mem[ld_addr] <= ld_data;
    else if (cs) begin
      if (we) begin
        if (wr_ev) mem[addr] <= merge(mem[addr], post[1:0], prog);
      end else begin
        sram_rdata <= mem[addr];
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (all_out !== '0) begin
      n_err++;
      $display("FAIL reset_state: got %h want 0", all_out);
    end
    n_cmp++;
    if (all_out2 !== '0) begin
      n_err++;
      $display("FAIL reset_state2: got %h want 0", all_out2);
    end
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    n_cmp++;
    if ({cs, we, addr} !== {1'b1, 1'b0, 16'd100}) begin
      n_err++;
      $display("FAIL reset_word100: got cs=%b we=%b addr=%0d want 1 0 100", cs, we, addr);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (all_out !== '0) begin
      n_err++;
      $display("FAIL reset_midsweep: got %h want 0", all_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (mon1 !== {8'b1001_0000, 16'd0, 10'd0, 10'd0}) begin
      n_err++;
      $display("FAIL reset_restart: got %h want %h", mon1, {8'b1001_0000, 36'd0});
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sweep();
    logic [43:0] exp;
    int          p;
    logic        rd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= SW1 + 1; k++) begin
      p  = (k - 1) / 2;
      rd = (k % 2) == 1;
      if (k <= SW1)
        exp = {1'b1, ~rd, ~rd, 1'b1, (k == SW1), 3'b000, 16'(p), 10'((p % W1) * 4), 10'(p / W1)};
      else
        exp = '0;
      n_cmp++;
      if (mon1 !== exp) begin
        n_err++;
        $display("FAIL sweep cycle %0d: got %h want %h", k, mon1, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_spi_write_read();
    gate    = 1'b1;
    ld      = 1'b1;
    ld_addr = 16'h0123;
    ld_data = 32'h1122_3344;
    @(negedge clk);
    ld = 1'b0;
    spi.SPI_REQ   = 1'b1;
    spi.SPI_WE    = 1'b1;
    spi.SPI_ADDR  = 16'h0123;
    spi.SPI_BYTE  = 2'd2;
    spi.SPI_WDATA = 8'hA5;
    @(negedge clk);  // cycle 1
    n_cmp++;
    if ({cs, we, rd_ev, wr_ev, addr, prog, spi.SPI_ACK} !== {4'b1010, 16'h0123, 8'hA5, 1'b0}) begin
      n_err++;
      $display("FAIL spiw_rd_phase: got cs%b we%b rd%b wr%b a=%h d=%h ack=%b want 1 0 1 0 0123 a5 0",
               cs, we, rd_ev, wr_ev, addr, prog, spi.SPI_ACK);
    end
    @(negedge clk);  // cycle 2
    n_cmp++;
    if ({cs, we, rd_ev, wr_ev, addr, post, spi.SPI_ACK} !== {4'b1101, 16'h0123, 10'd2, 1'b0}) begin
      n_err++;
      $display("FAIL spiw_wr_phase: got cs%b we%b rd%b wr%b a=%h post=%0d ack=%b want 1 1 0 1 0123 2 0",
               cs, we, rd_ev, wr_ev, addr, post, spi.SPI_ACK);
    end
    @(negedge clk);  // cycle 3
    n_cmp++;
    if ({cs, spi.SPI_ACK} !== 2'b00) begin
      n_err++;
      $display("FAIL spiw_cycle3: got cs=%b ack=%b want 0 0", cs, spi.SPI_ACK);
    end
    @(negedge clk);  // cycle 4
    n_cmp++;
    if (spi.SPI_ACK !== 1'b1) begin
      n_err++;
      $display("FAIL spiw_ack: got %b want 1", spi.SPI_ACK);
    end
    spi.SPI_REQ = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({spi.SPI_ACK, cs} !== 2'b00) begin
      n_err++;
      $display("FAIL spiw_ack_pulse: got ack=%b cs=%b want 0 0", spi.SPI_ACK, cs);
    end
    spi.SPI_REQ = 1'b1;
    spi.SPI_WE  = 1'b0;
    @(negedge clk);
    @(negedge clk);  // cycle 2
    n_cmp++;
    if (spi.SPI_ACK !== 1'b0) begin
      n_err++;
      $display("FAIL spir_early_ack: got %b want 0", spi.SPI_ACK);
    end
    @(negedge clk);  // cycle 3
    n_cmp++;
    if ({spi.SPI_ACK, spi.SPI_RDATA} !== {1'b1, 32'h11A5_3344}) begin
      n_err++;
      $display("FAIL spir_data: got ack=%b data=%h want 1 11a53344", spi.SPI_ACK, spi.SPI_RDATA);
    end
    spi.SPI_REQ = 1'b0;
    gate = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_arbitration();
    logic ack_seen;
    ack_seen      = 1'b0;
    gate          = 1'b0;
    spi.SPI_REQ   = 1'b1;
    spi.SPI_WE    = 1'b0;
    spi.SPI_ADDR  = 16'h0123;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      if (spi.SPI_ACK) ack_seen = 1'b1;
      if (k == 21) begin
        n_cmp++;
        if ({cs, we, addr} !== {2'b10, 16'd10}) begin
          n_err++;
          $display("FAIL arb_rd10: got cs=%b we=%b addr=%0d want 1 0 10", cs, we, addr);
        end
        gate = 1'b1;
      end
      if (k == 22) begin
        n_cmp++;
        if ({cs, we, tref, busy, abort, addr} !== {5'b11110, 16'd10}) begin
          n_err++;
          $display("FAIL arb_wr10: got cs%b we%b tref%b busy%b abort%b addr=%0d want 1 1 1 1 0 10",
                   cs, we, tref, busy, abort, addr);
        end
      end
      if (k == 23) begin
        n_cmp++;
        if ({abort, busy, cs} !== 3'b100) begin
          n_err++;
          $display("FAIL arb_abort: got abort=%b busy=%b cs=%b want 1 0 0", abort, busy, cs);
        end
      end
      if (k == 24) begin
        n_cmp++;
        if ({cs, rd_ev, addr} !== {2'b11, 16'h0123}) begin
          n_err++;
          $display("FAIL arb_spi_rd: got cs=%b rd=%b addr=%h want 1 1 0123", cs, rd_ev, addr);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (ack_seen !== 1'b0) begin
      n_err++;
      $display("FAIL arb_no_early_ack: got %b want 0", ack_seen);
    end
    n_cmp++;
    if ({spi.SPI_ACK, spi.SPI_RDATA} !== {1'b1, 32'h11A5_3344}) begin
      n_err++;
      $display("FAIL arb_pending_ack: got ack=%b data=%h want 1 11a53344", spi.SPI_ACK, spi.SPI_RDATA);
    end
    spi.SPI_REQ = 1'b0;
    gate = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_drops();
    int done_cnt, done_k;
    done_cnt = 0;
    done_k   = -1;
    gate  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      n_cmp++;
      if ({busy, cs, done} !== 3'b000) begin
        n_err++;
        $display("FAIL drop_gated cycle %0d: got busy=%b cs=%b done=%b want 0 0 0", k, busy, cs, done);
      end
      @(negedge clk);
    end
    gate = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= SW1 + 4; k++) begin
      if (done) begin
        done_cnt++;
        done_k = k;
      end
      if (k == 5) start = 1'b1;
      if (k == 6) start = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (done_cnt !== 1) begin
      n_err++;
      $display("FAIL drop_busy_done_count: got %0d want 1", done_cnt);
    end
    n_cmp++;
    if (done_k !== SW1) begin
      n_err++;
      $display("FAIL drop_busy_done_cycle: got %0d want %0d", done_k, SW1);
    end
  endtask

  task automatic test_boundary();
    logic [43:0] exp;
    int          p;
    logic        rd;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 1; k <= SW2 + 1; k++) begin
      p  = (k - 1) / 2;
      rd = (k % 2) == 1;
      if (k <= SW2)
        exp = {1'b1, ~rd, ~rd, 1'b1, (k == SW2), 3'b000, 16'(p), 10'((p % W2) * 4), 10'(p / W2)};
      else
        exp = '0;
      n_cmp++;
      if (mon2 !== exp) begin
        n_err++;
        $display("FAIL boundary cycle %0d: got %h want %h", k, mon2, exp);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; gate = 1'b0; start = 1'b0;
    ld = 1'b0; ld_addr = '0; ld_data = '0;
    spi.SPI_REQ = 1'b0; spi.SPI_WE = 1'b0; spi.SPI_ADDR = '0;
    spi.SPI_BYTE = '0; spi.SPI_WDATA = '0;
    gate2 = 1'b0; start2 = 1'b0; sram_rdata2 = '0;
    spi2.SPI_REQ = 1'b0; spi2.SPI_WE = 1'b0; spi2.SPI_ADDR = '0;
    spi2.SPI_BYTE = '0; spi2.SPI_WDATA = '0;

    test_reset();
    test_sweep();
    test_spi_write_read();
    test_arbitration();
    test_drops();
    test_boundary();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
